gpr_file_sb: RTL and testbench

Parametrised general-purpose register file for the pipelined core, successor to the single-write-port register file. It provides two combinational read ports with write-to-read bypass, two write ports with fixed priority, an optional hardwired-zero register 0, and a per-register scoreboard of pending writes for hazard detection. After reset, a sequential init engine clears the array one entry per cycle, so the storage maps to RAM without a flash reset.

---
 rtl/gpr_pkg.sv | 12 +
 rtl/gpr_scoreboard.sv | 58 +++++
 rtl/gpr_file_sb.sv | 127 ++++++++++++
 tb/tb_gpr_file_sb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared state type and default sizes for the register file
package gpr_pkg;

    localparam int GPR_XLEN = 32;
    localparam int GPR_NREG = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } gpr_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// rtl/gpr_scoreboard.sv - pending-write bits per register with set/clear priority
// and same-cycle busy lookup for the two read ports.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREG     = GPR_NREG,
    parameter bit ZERO_REG = 1'b1,
    parameter int AW       = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          alloc_i,
    input  logic [AW-1:0] alloc_rd_i,
    input  logic          clr0_i,
    input  logic [AW-1:0] clr0_addr_i,
    input  logic          clr1_i,
    input  logic [AW-1:0] clr1_addr_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          busy1_o,
    output logic          busy2_o
);

    localparam logic [AW-1:0] ZERO_ADDR = '0;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            set_ok;

    assign set_ok = en_i && alloc_i && !(ZERO_REG && (alloc_rd_i == ZERO_ADDR));

    // Set is applied last: a freshly issued producer outranks a retiring one.
    always_comb begin
        pending_d = pending_q;
        if (clr0_i) pending_d[clr0_addr_i] = 1'b0;
        if (clr1_i) pending_d[clr1_addr_i] = 1'b0;
        if (set_ok) pending_d[alloc_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        busy1_o = en_i && pending_q[rs1_i]
                  && !(clr0_i && (clr0_addr_i == rs1_i))
                  && !(clr1_i && (clr1_addr_i == rs1_i));
        busy2_o = en_i && pending_q[rs2_i]
                  && !(clr0_i && (clr0_addr_i == rs2_i))
                  && !(clr1_i && (clr1_addr_i == rs2_i));
    end

endmodule

// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - 2R/2W register file with write bypass, hardwired zero,
// sequential post-reset clearing and a pending-write scoreboard.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int              XLEN      = GPR_XLEN,
    parameter int              NREG      = GPR_NREG,
    parameter bit              ZERO_REG  = 1'b1,
    parameter logic [XLEN-1:0] RESET_VAL = '0,
    parameter int              AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we0,
    input  logic [AW-1:0]   ws0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   ws1,
    input  logic [XLEN-1:0] wd1,
    input  logic            alloc,
    input  logic [AW-1:0]   alloc_rd,
    output logic            ready
);

    localparam logic [AW-1:0] ZERO_ADDR = '0;
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

    gpr_state_e      state_q;
    gpr_state_e      state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic [XLEN-1:0] rf_q [NREG];

    logic run;
    logic init_we;
    logic commit0;
    logic commit1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (cnt_q == LAST_IDX) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        run     = (state_q == RUN);
        init_we = (state_q == INIT);
        ready   = run;
    end

    assign cnt_d = init_we ? cnt_q + 1'b1 : '0;

    assign commit0 = run && we0 && !(ZERO_REG && (ws0 == ZERO_ADDR));
    assign commit1 = run && we1 && !(ZERO_REG && (ws1 == ZERO_ADDR));

    // No reset on the array so it can map onto RAM; the init engine clears it.
    always_ff @(posedge clk) begin
        if (init_we) begin
            rf_q[cnt_q] <= RESET_VAL;
        end else begin
            if (commit0) rf_q[ws0] <= wd0;
            if (commit1) rf_q[ws1] <= wd1;
        end
    end

    function automatic logic [XLEN-1:0] read_port(
        input logic            en,
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] stored,
        input logic            c0,
        input logic [AW-1:0]   a0,
        input logic [XLEN-1:0] d0,
        input logic            c1,
        input logic [AW-1:0]   a1,
        input logic [XLEN-1:0] d1
    );
        if (!en || (ZERO_REG && (rs == ZERO_ADDR))) return '0;
        if (c1 && (a1 == rs))                        return d1;
        if (c0 && (a0 == rs))                        return d0;
        return stored;
    endfunction

    always_comb begin
        rd1 = read_port(run, rs1, rf_q[rs1], commit0, ws0, wd0, commit1, ws1, wd1);
        rd2 = read_port(run, rs2, rf_q[rs2], commit0, ws0, wd0, commit1, ws1, wd1);
    end

    gpr_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (run),
        .alloc_i     (alloc),
        .alloc_rd_i  (alloc_rd),
        .clr0_i      (commit0),
        .clr0_addr_i (ws0),
        .clr1_i      (commit1),
        .clr1_addr_i (ws1),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .busy1_o     (busy1),
        .busy2_o     (busy2)
    );

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - vector table, corner sequences and randomized
// reference-model comparison for gpr_file_sb.
module tb_gpr_file_sb;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, ws0, ws1, alloc_rd;
    logic [31:0] rd1, rd2, wd0, wd1;
    logic        busy1, busy2, we0, we1, alloc, ready;

    int errors = 0;
    int checks = 0;

    gpr_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd1      (rd1),
        .rd2      (rd2),
        .busy1    (busy1),
        .busy2    (busy2),
        .we0      (we0),
        .ws0      (ws0),
        .wd0      (wd0),
        .we1      (we1),
        .ws1      (ws1),
        .wd1      (wd1),
        .alloc    (alloc),
        .alloc_rd (alloc_rd),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  ws0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  ws1;
        logic [31:0] wd1;
        logic        alloc;
        logic [4:0]  alloc_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    vec_t vecs[13];

    logic [31:0] m_rf   [32];
    bit          m_pend [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; ws0 = '0; wd0 = '0;
        we1 = 1'b0; ws1 = '0; wd1 = '0;
        alloc = 1'b0; alloc_rd = '0;
    endtask

    function automatic bit m_hit(input logic [4:0] a);
        return (a != 5'd0) && ((we1 && ws1 == a) || (we0 && ws0 == a));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0)            return 32'h0;
        if (we1 && ws1 == a)      return wd1;
        if (we0 && ws0 == a)      return wd0;
        return m_rf[a];
    endfunction

    initial begin
        //          we0   ws0    wd0           we1   ws1    wd1           al    ard    rs1    rs2    e_rd1         e_rd2         b1    b2
        vecs[0]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd2, 5'd7, 32'h0,       32'h0,       1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd5, 32'hAAAA,    1'b1, 5'd5, 32'h5555,    1'b0, 5'd0, 5'd5, 5'd5, 32'h5555,    32'h5555,    1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd5, 5'd0, 32'h5555,    32'h0,       1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b1, 5'd7, 5'd7, 5'd5, 32'h0,       32'h5555,    1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd7, 5'd7, 32'h0,       32'h0,       1'b1, 1'b1};
        vecs[5]  = '{1'b1, 5'd7, 32'h77,      1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd7, 5'd5, 32'h77,      32'h5555,    1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd7, 5'd7, 32'h77,      32'h77,      1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,       1'b1, 5'd7, 32'h88,      1'b1, 5'd7, 5'd7, 5'd7, 32'h88,      32'h88,      1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd7, 5'd7, 32'h88,      32'h88,      1'b1, 1'b1};
        vecs[9]  = '{1'b1, 5'd0, 32'hFFFF,    1'b1, 5'd0, 32'hFFFF,    1'b1, 5'd0, 5'd0, 5'd0, 32'h0,       32'h0,       1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd7, 32'h0,       32'h88,      1'b0, 1'b1};
        vecs[11] = '{1'b1, 5'd3, 32'h1234,    1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd5, 5'd3, 32'h5555,    32'h1234,    1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd3, 5'd7, 32'h1234,    32'h88,      1'b0, 1'b1};

        rst = 1'b1;
        idle();
        rs1 = 5'd0; rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_rd2", rd2, 32'h0);
        chk("reset_busy", {30'b0, busy1, busy2}, 32'h0);

        // Writes and allocs during INIT must be ignored.
        @(negedge clk);
        rst = 1'b0;
        we1 = 1'b1; ws1 = 5'd2; wd1 = 32'h99;
        alloc = 1'b1; alloc_rd = 5'd2;
        rs1 = 5'd2; rs2 = 5'd2;
        for (int e = 1; e <= NREG; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ready_edge%0d", e), {31'b0, ready}, {31'b0, (e == NREG)});
            if (e < NREG) begin
                chk("init_rd1", rd1, 32'h0);
                chk("init_busy1", {31'b0, busy1}, 32'h0);
            end
            if (e == NREG - 1) begin
                @(negedge clk);
                idle();
            end
        end

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            we0 = vecs[i].we0; ws0 = vecs[i].ws0; wd0 = vecs[i].wd0;
            we1 = vecs[i].we1; ws1 = vecs[i].ws1; wd1 = vecs[i].wd1;
            alloc = vecs[i].alloc; alloc_rd = vecs[i].alloc_rd;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
            chk($sformatf("vec%0d_busy1", i), {31'b0, busy1}, {31'b0, vecs[i].e_b1});
            chk($sformatf("vec%0d_busy2", i), {31'b0, busy2}, {31'b0, vecs[i].e_b2});
        end

        // Mid-run reset: x3 holds 0x1234 and x7 is pending.
        @(negedge clk);
        idle();
        rst = 1'b1;
        rs1 = 5'd3; rs2 = 5'd7;
        @(posedge clk);
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'h0);
        chk("midrst_busy2", {31'b0, busy2}, 32'h0);
        chk("midrst_rd1", rd1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (NREG - 1) @(posedge clk);
        #1;
        chk("midrst_ready_early", {31'b0, ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_ready_late", {31'b0, ready}, 32'h1);
        chk("midrst_x3", rd1, 32'h0);
        chk("midrst_x7_busy", {31'b0, busy2}, 32'h0);

        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'h0;
            m_pend[r] = 1'b0;
        end

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we0 = 1'($urandom_range(0, 1));
            ws0 = 5'($urandom_range(0, 7));
            wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1));
            ws1 = 5'($urandom_range(0, 7));
            wd1 = $urandom;
            alloc = 1'($urandom_range(0, 1));
            alloc_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            #1;
            chk("rand_rd1", rd1, m_read(rs1));
            chk("rand_rd2", rd2, m_read(rs2));
            chk("rand_busy1", {31'b0, busy1}, {31'b0, (m_pend[rs1] && !m_hit(rs1))});
            chk("rand_busy2", {31'b0, busy2}, {31'b0, (m_pend[rs2] && !m_hit(rs2))});
            if (we0 && ws0 != 5'd0) begin
                m_rf[ws0] = wd0;
                m_pend[ws0] = 1'b0;
            end
            if (we1 && ws1 != 5'd0) begin
                m_rf[ws1] = wd1;
                m_pend[ws1] = 1'b0;
            end
            if (alloc && alloc_rd != 5'd0) m_pend[alloc_rd] = 1'b1;
        end

        @(negedge clk);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
